pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
- REQ-001 Parameter WIDTH, default 32, meaning PC bit width (legal 16..64).
- REQ-002 Parameter RESET_VECTOR, default 32'h0000_3000, meaning curr_pc value after reset.
- REQ-003 Parameter EXC_VECTOR, default 32'h0000_4180, meaning exception entry address.
- REQ-004 Parameter STEP, default 4, meaning sequential increment (power of two, >=1).
- REQ-005 Port clk, input, 1, meaning the single clock; all state updates on rising edge.
- REQ-006 Port reset_n, input, 1, meaning asynchronous active-low reset.
- REQ-007 Port enable, input, 1, meaning 1 = PC advances or redirects, 0 = stall (hold).
- REQ-008 Port redir_valid, input, 1, meaning branch/jump redirect request this cycle.
- REQ-009 Port redir_target, input, WIDTH, meaning redirect address.
- REQ-010 Port exc_valid, input, 1, meaning exception request this cycle.
- REQ-011 Port eret_valid, input, 1, meaning exception-return request this cycle.
- REQ-012 Port curr_pc, output, WIDTH, meaning the registered current PC.
- REQ-013 Port epc, output, WIDTH, meaning the registered exception PC.
- REQ-014 Port pending, output, 1, meaning a stalled redirect is buffered.
- REQ-015 Port misalign, output, 1, meaning a registered one-cycle pulse indicating a misaligned redirect was trapped.

Function
- REQ-016 An address SHALL be misaligned when its low log2(STEP) bits are nonzero; STEP=1 means no address is ever misaligned.
- REQ-017 Each edge SHALL select exactly one action, in priority order: exception, eret, redirect, sequential, hold.
- REQ-018 Exception (exc_valid=1, enable ignored): epc <= curr_pc; curr_pc <= EXC_VECTOR; pending <= 0.
- REQ-019 Eret (eret_valid=1, enable=1, no exception): curr_pc <= epc; pending <= 0; epc unchanged.
- REQ-020 Redirect (enable=1, redir_valid=1 or pending=1, no exc/eret): target SHALL be redir_target if redir_valid=1, else the buffered target; curr_pc <= target; pending <= 0.
- REQ-021 A misaligned redirect target SHALL NOT load curr_pc; instead epc <= target; curr_pc <= EXC_VECTOR; pending <= 0; misalign <= 1.
- REQ-022 Sequential (enable=1, no other request, pending=0): curr_pc <= curr_pc + STEP, modulo 2^WIDTH (wraps silently).
- REQ-023 Hold (enable=0, no exception): curr_pc and epc SHALL be unchanged.
- REQ-024 Redirect while stalled (enable=0, redir_valid=1, no exception): buffer redir_target; pending <= 1; a newer stalled redirect SHALL overwrite the older one.
- REQ-025 Eret with enable=0 SHALL be ignored (not buffered).
- REQ-026 misalign SHALL be 1 only in the cycle following a trap per REQ-021, else 0.
- REQ-027 Action latency SHALL be exactly one edge; outputs SHALL come directly from registers.

Reset
- REQ-028 reset_n=0 SHALL immediately, without waiting for a clock edge, set curr_pc=RESET_VECTOR, epc=0, pending=0, misalign=0, and clear the buffered target to 0.
- REQ-029 While reset_n=0, all inputs SHALL be ignored; first update on the first rising edge after reset_n rises.
- REQ-030 Reset asserted mid-stall SHALL discard any buffered redirect.

Verification
- REQ-031 Reset, then enable=1 for 3 edges -> curr_pc 0x3000, 0x3004, 0x3008, 0x300C.
- REQ-032 At 0x3008, enable=0, redir_valid=1 target 0x3100, then target 0x3200 next cycle, then enable=1 -> curr_pc holds 0x3008 and pending=1 while stalled; next edge -> curr_pc=0x3200, pending=0.
- REQ-033 curr_pc=0x3010, exc_valid=1 together with redir_valid=1 -> curr_pc=0x4180, epc=0x3010; later eret_valid=1 with enable=1 -> curr_pc=0x3010.
- REQ-034 Redirect to 0x3102 with enable=1 -> curr_pc=0x4180, epc=0x3102, misalign pulses high for exactly one cycle.
- REQ-035 WIDTH=16, RESET_VECTOR=16'hFFFC, enable=1 -> curr_pc 0xFFFC then 0x0000 (wrap).
- REQ-036 reset_n pulled low between edges with pending=1 -> curr_pc=0x3000 and pending=0 before the next edge; after release, sequential from 0x3000.

Source files
------------

// File: rtl/pc_ctrl.sv
// Program-counter controller: sequential fetch, branch redirect with stall buffering,
// exception entry/return, and trapping of misaligned redirect targets.
module pc_ctrl #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = 'h0000_3000,
   parameter logic [WIDTH-1:0] EXC_VECTOR   = 'h0000_4180,
   parameter int               STEP         = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             redir_valid,
   input  logic [WIDTH-1:0] redir_target,
   input  logic             exc_valid,
   input  logic             eret_valid,
   output logic [WIDTH-1:0] curr_pc,
   output logic [WIDTH-1:0] epc,
   output logic             pending,
   output logic             misalign
);

   // With STEP a power of two, STEP-1 covers exactly the bits that must be zero.
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
   localparam logic [WIDTH-1:0] STEP_INC   = WIDTH'(STEP);

   function automatic logic f_misaligned(input logic [WIDTH-1:0] addr);
      return |(addr & ALIGN_MASK);
   endfunction

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_epc;
   logic [WIDTH-1:0] r_buf_target;
   logic             r_pending;
   logic             r_misalign;

   logic [WIDTH-1:0] w_pc_nxt;
   logic [WIDTH-1:0] w_epc_nxt;
   logic [WIDTH-1:0] w_buf_nxt;
   logic             w_pending_nxt;
   logic             w_misalign_nxt;
   logic [WIDTH-1:0] w_target;

   assign w_target = redir_valid ? redir_target : r_buf_target;

   always_comb begin
      w_pc_nxt       = r_pc;
      w_epc_nxt      = r_epc;
      w_buf_nxt      = r_buf_target;
      w_pending_nxt  = r_pending;
      w_misalign_nxt = 1'b0;

      if (exc_valid) begin
         w_epc_nxt     = r_pc;
         w_pc_nxt      = EXC_VECTOR;
         w_pending_nxt = 1'b0;
      end else if (enable && eret_valid) begin
         w_pc_nxt      = r_epc;
         w_pending_nxt = 1'b0;
      end else if (enable && (redir_valid || r_pending)) begin
         w_pending_nxt = 1'b0;
         // A misaligned target never reaches curr_pc; it is reported through epc.
         if (f_misaligned(w_target)) begin
            w_epc_nxt      = w_target;
            w_pc_nxt       = EXC_VECTOR;
            w_misalign_nxt = 1'b1;
         end else begin
            w_pc_nxt = w_target;
         end
      end else if (enable) begin
         w_pc_nxt = r_pc + STEP_INC;
      end else if (redir_valid) begin
         // Stalled: keep only the newest redirect; a stalled eret is dropped.
         w_buf_nxt     = redir_target;
         w_pending_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc         <= RESET_VECTOR;
         r_epc        <= '0;
         r_buf_target <= '0;
         r_pending    <= 1'b0;
         r_misalign   <= 1'b0;
      end else begin
         r_pc         <= w_pc_nxt;
         r_epc        <= w_epc_nxt;
         r_buf_target <= w_buf_nxt;
         r_pending    <= w_pending_nxt;
         r_misalign   <= w_misalign_nxt;
      end
   end

   assign curr_pc  = r_pc;
   assign epc      = r_epc;
   assign pending  = r_pending;
   assign misalign = r_misalign;

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: a 32-bit instance with the default vectors and a
// 16-bit instance exercising address wrap and misalign trapping.
module tb_pc_ctrl;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] epc;
      logic        pend;
      logic        mis;
      string       nm;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable, redir_valid, exc_valid, eret_valid;
   logic [31:0] redir_target;
   logic [31:0] curr_pc, epc;
   logic        pending, misalign;

   logic        rst16_n;
   logic        en16, rv16, exc16, eret16;
   logic [15:0] rt16;
   logic [15:0] pc16, epc16;
   logic        pend16, mis16;

   exp_t q32[$];
   exp_t q16[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   done16 = 1'b0;

   always #5 clk = ~clk;

   pc_ctrl dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .redir_valid(redir_valid),
      .redir_target(redir_target), .exc_valid(exc_valid), .eret_valid(eret_valid),
      .curr_pc(curr_pc), .epc(epc), .pending(pending), .misalign(misalign)
   );

   pc_ctrl #(.WIDTH(16), .RESET_VECTOR(16'hFFFC), .EXC_VECTOR(16'h4180), .STEP(4)) dut16 (
      .clk(clk), .reset_n(rst16_n), .enable(en16), .redir_valid(rv16),
      .redir_target(rt16), .exc_valid(exc16), .eret_valid(eret16),
      .curr_pc(pc16), .epc(epc16), .pending(pend16), .misalign(mis16)
   );

   function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] ep,
                               input logic pd, input logic ms, input string nm);
      exp_t e;
      e.pc = pc; e.epc = ep; e.pend = pd; e.mis = ms; e.nm = nm;
      return e;
   endfunction

   // Monitors: one pop per falling edge, mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (q32.size() > 0) begin
         exp_t e;
         e = q32.pop_front();
         n_cmp++;
         if (curr_pc !== e.pc || epc !== e.epc || pending !== e.pend || misalign !== e.mis) begin
            n_bad++;
            $display("FAIL %s: got pc=%h epc=%h pend=%b mis=%b, want pc=%h epc=%h pend=%b mis=%b",
                     e.nm, curr_pc, epc, pending, misalign, e.pc, e.epc, e.pend, e.mis);
         end
      end
   end

   always @(negedge clk) begin
      if (q16.size() > 0) begin
         exp_t e;
         e = q16.pop_front();
         n_cmp++;
         if (pc16 !== e.pc[15:0] || epc16 !== e.epc[15:0] || pend16 !== e.pend || mis16 !== e.mis) begin
            n_bad++;
            $display("FAIL %s: got pc=%h epc=%h pend=%b mis=%b, want pc=%h epc=%h pend=%b mis=%b",
                     e.nm, pc16, epc16, pend16, mis16, e.pc[15:0], e.epc[15:0], e.pend, e.mis);
         end
      end
   end

   // Drive one edge's inputs, then queue the state expected right after that edge.
   task automatic step(input logic en, input logic rv, input logic [31:0] rt,
                       input logic exc, input logic er,
                       input logic [31:0] pc, input logic [31:0] ep,
                       input logic pd, input logic ms, input string nm);
      enable = en; redir_valid = rv; redir_target = rt; exc_valid = exc; eret_valid = er;
      @(posedge clk);
      q32.push_back(mk(pc, ep, pd, ms, nm));
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      enable = 1'b0; redir_valid = 1'b0; redir_target = '0; exc_valid = 1'b0; eret_valid = 1'b0;
      #2;
      q32.push_back(mk(32'h3000, 32'h0, 1'b0, 1'b0, "reset_state"));
      @(negedge clk);
      step(1, 1, 32'h5000, 1, 1, 32'h3000, 32'h0, 0, 0, "reset_ignores_inputs");
      reset_n = 1'b1;

      //        en rv target       exc er  pc            epc           pd ms
      step(1, 0, 32'h0,    0, 0, 32'h3004, 32'h0,    0, 0, "seq_1");
      step(1, 0, 32'h0,    0, 0, 32'h3008, 32'h0,    0, 0, "seq_2");
      step(0, 1, 32'h3100, 0, 0, 32'h3008, 32'h0,    1, 0, "stall_redir_a");
      step(0, 1, 32'h3200, 0, 0, 32'h3008, 32'h0,    1, 0, "stall_redir_b");
      step(0, 0, 32'h0,    0, 1, 32'h3008, 32'h0,    1, 0, "stalled_eret_ignored");
      step(1, 0, 32'h0,    0, 0, 32'h3200, 32'h0,    0, 0, "pending_redir_newest");
      step(1, 0, 32'h0,    0, 0, 32'h3204, 32'h0,    0, 0, "seq_after_redir");
      step(1, 1, 32'h3010, 0, 0, 32'h3010, 32'h0,    0, 0, "redir_direct");
      step(1, 1, 32'h5000, 1, 0, 32'h4180, 32'h3010, 0, 0, "exc_over_redir");
      step(1, 0, 32'h0,    0, 0, 32'h4184, 32'h3010, 0, 0, "seq_in_handler");
      step(0, 0, 32'h0,    0, 0, 32'h4184, 32'h3010, 0, 0, "hold");
      step(1, 0, 32'h0,    0, 1, 32'h3010, 32'h3010, 0, 0, "eret");
      step(1, 1, 32'h3102, 0, 0, 32'h4180, 32'h3102, 0, 1, "misalign_trap");
      step(1, 0, 32'h0,    0, 0, 32'h4184, 32'h3102, 0, 0, "misalign_one_cycle");
      step(0, 1, 32'h3106, 0, 0, 32'h4184, 32'h3102, 1, 0, "stall_misaligned");
      step(1, 0, 32'h0,    0, 0, 32'h4180, 32'h3106, 0, 1, "pending_misalign_trap");
      step(0, 0, 32'h0,    1, 0, 32'h4180, 32'h4180, 0, 0, "exc_while_stalled");
      step(0, 1, 32'h3300, 0, 0, 32'h4180, 32'h4180, 1, 0, "stall_redir_c");
      step(1, 0, 32'h0,    1, 0, 32'h4180, 32'h4180, 0, 0, "exc_clears_pending");
      step(1, 0, 32'h0,    0, 0, 32'h4184, 32'h4180, 0, 0, "buffer_discarded");
      step(1, 0, 32'h0,    0, 1, 32'h4180, 32'h4180, 0, 0, "eret_2");
      step(0, 1, 32'h3400, 0, 0, 32'h4180, 32'h4180, 1, 0, "stall_redir_d");

      // Reset dropped between edges must take effect before the next edge.
      enable = 1'b0; redir_valid = 1'b1; redir_target = 32'h3500; exc_valid = 1'b0; eret_valid = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      q32.push_back(mk(32'h3000, 32'h0, 1'b0, 1'b0, "async_reset_midstall"));
      step(1, 0, 32'h0,    1, 0, 32'h3000, 32'h0,    0, 0, "reset_held");
      reset_n = 1'b1;

      step(1, 0, 32'h0,    0, 0, 32'h3004, 32'h0,    0, 0, "post_reset_seq_1");
      step(1, 0, 32'h0,    0, 0, 32'h3008, 32'h0,    0, 0, "post_reset_seq_2");
      step(1, 0, 32'h0,    0, 0, 32'h300C, 32'h0,    0, 0, "post_reset_seq_3");
      step(1, 0, 32'h0,    1, 1, 32'h4180, 32'h300C, 0, 0, "exc_over_eret");
      step(0, 1, 32'h3500, 0, 0, 32'h4180, 32'h300C, 1, 0, "stall_redir_e");
      step(1, 1, 32'h3600, 0, 0, 32'h3600, 32'h300C, 0, 0, "new_redir_over_buffer");
      step(1, 1, 32'h3700, 0, 1, 32'h300C, 32'h300C, 0, 0, "eret_over_redir");
      step(0, 0, 32'h0,    0, 0, 32'h300C, 32'h300C, 0, 0, "final_hold");

      for (int i = 0; i < 20 && (q32.size() > 0 || q16.size() > 0 || !done16); i++)
         @(negedge clk);
      #1;
      if (q32.size() > 0 || q16.size() > 0 || !done16) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got q32=%0d q16=%0d done16=%0d, want 0 0 1",
                  q32.size(), q16.size(), done16);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      rst16_n = 1'b0;
      en16 = 1'b0; rv16 = 1'b0; rt16 = '0; exc16 = 1'b0; eret16 = 1'b0;
      #2;
      q16.push_back(mk(32'hFFFC, 32'h0, 1'b0, 1'b0, "w16_reset_state"));
      @(negedge clk);
      en16 = 1'b1;
      @(posedge clk);
      q16.push_back(mk(32'hFFFC, 32'h0, 1'b0, 1'b0, "w16_reset_held"));
      #1;
      rst16_n = 1'b1;
      @(posedge clk);
      q16.push_back(mk(32'h0000, 32'h0, 1'b0, 1'b0, "w16_wrap"));
      #1;
      @(posedge clk);
      q16.push_back(mk(32'h0004, 32'h0, 1'b0, 1'b0, "w16_seq"));
      #1;
      rv16 = 1'b1; rt16 = 16'h0006;
      @(posedge clk);
      q16.push_back(mk(32'h4180, 32'h0006, 1'b0, 1'b1, "w16_misalign"));
      #1;
      rv16 = 1'b0;
      @(posedge clk);
      q16.push_back(mk(32'h4184, 32'h0006, 1'b0, 1'b0, "w16_after_trap"));
      #1;
      done16 = 1'b1;
   end

endmodule
